addr_reg_stack: RTL and testbench
=================================

# addr_reg_stack

Parametrised address register with load, stride-increment, signed-offset add and a small LIFO return stack for call/return sequencing. Successor to the plain load-every-cycle address/opcode register: holds its value unless commanded, and supports wrap-around arithmetic. Sits between the control unit (which drives `op`) and the instruction memory address input.

## Interface
- `WIDTH`, 10, address/data width in bits
- `DEPTH`, 4, return-stack entries (≥1)
- `STRIDE`, 1, unsigned increment applied by INC and by CALL's return address

- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset, synchronous and active-low (asserted when 0, sampled on `clk` rising edge)
- `op`  input  3  command, sampled every rising edge
- `din`  input  WIDTH  load/call target
- `offset`  input  WIDTH  two's-complement offset for ADD
- `addr`  output  WIDTH  current address register
- `depth`  output  $clog2(DEPTH+1)  number of valid stack entries
- `empty`  output  1  `depth == 0`
- `full`  output  1  `depth == DEPTH`
- `err`  output  1  sticky overflow/underflow flag

## Operation
- Op encoding: 000 HOLD; 001 LOAD (`addr<=din`); 010 INC (`addr<=addr+STRIDE`); 011 ADD (`addr<=addr+offset`); 100 CALL; 101 RET; 110 CLRERR (`err<=0`, addr holds); 111 reserved, behaves as HOLD.
- Arithmetic modulo 2^WIDTH; carries discarded, no flag (0x3FF+1 → 0x000 at WIDTH=10). ADD with offset 0x3FE subtracts 2.
- CALL, not full: push `(addr+STRIDE) mod 2^WIDTH`, `addr<=din`, depth+1.
- CALL, full: nothing changes (addr, stack, depth), `err<=1`.
- RET, not empty: `addr<=top`, depth−1.
- RET, empty: nothing changes, `err<=1`.
- `err` sticky: cleared only by CLRERR or reset; an overflow/underflow on the same cycle is impossible with CLRERR (single op).
- Stack storage contents below `depth` are don't-care; never observable on outputs.
- `empty`/`full` derived from registered `depth`; no combinational path from `op`/`din`/`offset` to any output.

## Timing
- All state updates on rising `clk`; results visible the cycle after the edge on which `op` was sampled (latency 1).
- Back-to-back ops allowed every cycle; CALL then RET on consecutive cycles restores `addr` to pre-CALL value + STRIDE.
- Reset (`rst`=0 at edge) overrides any `op` that cycle: `addr`=0, `depth`=0, `empty`=1, `full`=0, `err`=0. Stack contents need not be cleared.
- Reset mid-sequence (e.g. with stack partially filled) discards all pending returns; next RET underflows.
- Before the first reset edge outputs are undefined; bench applies reset ≥1 cycle.

## Configuration
- Macro `AR_RETSTACK_EN`.
- Defined: return stack, CALL/RET as above.
- Undefined: no stack storage; CALL and RET behave as HOLD and do not touch `err`; `depth` tied 0, `empty` tied 1, `full` tied 0. LOAD/INC/ADD/CLRERR unchanged; `err` then stays 0 permanently.

## Test plan
- Reset: hold `rst`=0 two cycles with `op`=001, `din`=0x155 → `addr`=0, `depth`=0, `empty`=1, `full`=0, `err`=0.
- Wrap: LOAD 0x3FF, INC → `addr`=0x000; LOAD 5, ADD `offset`=0x3FE → `addr`=3; HOLD 3 cycles → stays 3.
- Call/return LIFO (DEPTH=4): from `addr`=0x010 CALL 0x100, CALL 0x200, CALL 0x300 → depth 3; RET×3 → `addr` 0x201, 0x101, 0x011; `empty`=1.
- Overflow: 4 CALLs → `full`=1; 5th CALL with `din`=0x3AA → `addr`, depth unchanged, `err`=1; HOLD → `err` stays 1; CLRERR → `err`=0.
- Underflow: with `empty`=1, RET → `addr` unchanged, `err`=1.
- Reset mid-op: depth 2, assert `rst` with `op`=101 → `addr`=0, depth 0; following RET sets `err`=1. Repeat build without `AR_RETSTACK_EN`: CALL leaves `addr` unchanged, `err`=0, `empty`=1.

Source files
------------

// File: rtl/addr_reg_stack.sv
// Address register with load, stride increment, signed offset add and a LIFO return stack.
// Define AR_RETSTACK_EN to build the return stack; without it CALL/RET act as HOLD.
module addr_reg_stack #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 4,
    parameter int STRIDE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           din,
    input  logic [WIDTH-1:0]           offset,
    output logic [WIDTH-1:0]           addr,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       err
);

    localparam int DW = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_INC    = 3'b010;
    localparam logic [2:0] OP_ADD    = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;
    localparam logic [2:0] OP_CLRERR = 3'b110;

    localparam logic [WIDTH-1:0] STRIDE_W = WIDTH'(STRIDE);

    logic [WIDTH-1:0] addr_nxt;
    logic             err_nxt;

`ifdef AR_RETSTACK_EN
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_nxt;
    logic             push_en;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    top_idx;

    assign push_idx = IW'(depth_q);
    assign top_idx  = IW'(depth_q - DW'(1));

    always_comb begin
        addr_nxt  = addr;
        err_nxt   = err;
        depth_nxt = depth_q;
        push_en   = 1'b0;
        case (op)
            OP_LOAD:   addr_nxt = din;
            OP_INC:    addr_nxt = addr + STRIDE_W;
            OP_ADD:    addr_nxt = addr + offset;
            OP_CALL: begin
                if (full) begin
                    err_nxt = 1'b1;
                end else begin
                    push_en   = 1'b1;
                    addr_nxt  = din;
                    depth_nxt = depth_q + DW'(1);
                end
            end
            OP_RET: begin
                if (empty) begin
                    err_nxt = 1'b1;
                end else begin
                    addr_nxt  = stack[top_idx];
                    depth_nxt = depth_q - DW'(1);
                end
            end
            OP_CLRERR: err_nxt = 1'b0;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_nxt;
        end
    end

    // Storage needs no reset: entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (rst && push_en) begin
            stack[push_idx] <= addr + STRIDE_W;
        end
    end

    assign depth = depth_q;
    assign empty = (depth_q == '0);
    assign full  = (depth_q == DW'(DEPTH));
`else
    always_comb begin
        addr_nxt = addr;
        err_nxt  = err;
        case (op)
            OP_LOAD:   addr_nxt = din;
            OP_INC:    addr_nxt = addr + STRIDE_W;
            OP_ADD:    addr_nxt = addr + offset;
            OP_CLRERR: err_nxt  = 1'b0;
            default:   ;
        endcase
    end

    assign depth = '0;
    assign empty = 1'b1;
    assign full  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr <= '0;
            err  <= 1'b0;
        end else begin
            addr <= addr_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_addr_reg_stack.sv
// Directed bench for addr_reg_stack; expectations queued at drive time, checked after the edge.
module tb_addr_reg_stack;

    localparam int WIDTH = 10;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       op  = 3'b000;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] offset = '0;
    logic [WIDTH-1:0] addr;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             err;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] addr;
        logic [DW-1:0]    depth;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    addr_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STRIDE(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .op     (op),
        .din    (din),
        .offset (offset),
        .addr   (addr),
        .depth  (depth),
        .empty  (empty),
        .full   (full),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] ofs, input logic [WIDTH-1:0] ea,
                        input int ed, input logic ee);
        exp_t e;
        exp_t got;
        logic exp_empty;
        logic exp_full;
        op     = o;
        din    = d;
        offset = ofs;
        e.tag   = tag;
        e.addr  = ea;
        e.depth = DW'(ed);
        e.err   = ee;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got       = exp_q.pop_front();
        exp_empty = (got.depth == '0);
        exp_full  = (got.depth == DW'(DEPTH));
        n_cmp++;
        assert (addr === got.addr) else begin
            n_bad++;
            $error("FAIL %s addr obs=%h exp=%h", got.tag, addr, got.addr);
        end
        n_cmp++;
        assert (depth === got.depth) else begin
            n_bad++;
            $error("FAIL %s depth obs=%0d exp=%0d", got.tag, depth, got.depth);
        end
        n_cmp++;
        assert (empty === exp_empty) else begin
            n_bad++;
            $error("FAIL %s empty obs=%b exp=%b", got.tag, empty, exp_empty);
        end
        n_cmp++;
        assert (full === exp_full) else begin
            n_bad++;
            $error("FAIL %s full obs=%b exp=%b", got.tag, full, exp_full);
        end
        n_cmp++;
        assert (err === got.err) else begin
            n_bad++;
            $error("FAIL %s err obs=%b exp=%b", got.tag, err, got.err);
        end
    endtask

    initial begin
        rst = 1'b0;
        step("rst0", 3'b001, 10'h155, 10'h000, 10'h000, 0, 1'b0);
        step("rst1", 3'b001, 10'h155, 10'h000, 10'h000, 0, 1'b0);
        rst = 1'b1;

        step("load3ff", 3'b001, 10'h3FF, 10'h000, 10'h3FF, 0, 1'b0);
        step("incwrap", 3'b010, 10'h000, 10'h000, 10'h000, 0, 1'b0);
        step("load5",   3'b001, 10'h005, 10'h000, 10'h005, 0, 1'b0);
        step("addneg2", 3'b011, 10'h000, 10'h3FE, 10'h003, 0, 1'b0);
        step("hold1",   3'b000, 10'h2AA, 10'h111, 10'h003, 0, 1'b0);
        step("hold2",   3'b000, 10'h2AA, 10'h111, 10'h003, 0, 1'b0);
        step("hold3",   3'b000, 10'h2AA, 10'h111, 10'h003, 0, 1'b0);
        step("resv",    3'b111, 10'h2AA, 10'h111, 10'h003, 0, 1'b0);
        step("addpos",  3'b011, 10'h000, 10'h07D, 10'h080, 0, 1'b0);
        step("clrerr0", 3'b110, 10'h2AA, 10'h000, 10'h080, 0, 1'b0);

`ifdef AR_RETSTACK_EN
        step("load010", 3'b001, 10'h010, 10'h000, 10'h010, 0, 1'b0);
        step("call100", 3'b100, 10'h100, 10'h000, 10'h100, 1, 1'b0);
        step("call200", 3'b100, 10'h200, 10'h000, 10'h200, 2, 1'b0);
        step("call300", 3'b100, 10'h300, 10'h000, 10'h300, 3, 1'b0);
        step("ret201",  3'b101, 10'h000, 10'h000, 10'h201, 2, 1'b0);
        step("ret101",  3'b101, 10'h000, 10'h000, 10'h101, 1, 1'b0);
        step("ret011",  3'b101, 10'h000, 10'h000, 10'h011, 0, 1'b0);

        step("ovcall1", 3'b100, 10'h080, 10'h000, 10'h080, 1, 1'b0);
        step("ovcall2", 3'b100, 10'h090, 10'h000, 10'h090, 2, 1'b0);
        step("ovcall3", 3'b100, 10'h0A0, 10'h000, 10'h0A0, 3, 1'b0);
        step("ovcall4", 3'b100, 10'h0B0, 10'h000, 10'h0B0, 4, 1'b0);
        step("ovcall5", 3'b100, 10'h3AA, 10'h000, 10'h0B0, 4, 1'b1);
        step("ovhold",  3'b000, 10'h000, 10'h000, 10'h0B0, 4, 1'b1);
        step("ovclr",   3'b110, 10'h000, 10'h000, 10'h0B0, 4, 1'b0);
        step("ovret1",  3'b101, 10'h000, 10'h000, 10'h0A1, 3, 1'b0);
        step("ovret2",  3'b101, 10'h000, 10'h000, 10'h091, 2, 1'b0);
        step("ovret3",  3'b101, 10'h000, 10'h000, 10'h081, 1, 1'b0);
        step("ovret4",  3'b101, 10'h000, 10'h000, 10'h012, 0, 1'b0);

        step("underret", 3'b101, 10'h000, 10'h000, 10'h012, 0, 1'b1);
        step("underclr", 3'b110, 10'h000, 10'h000, 10'h012, 0, 1'b0);

        step("wrpload", 3'b001, 10'h3FF, 10'h000, 10'h3FF, 0, 1'b0);
        step("wrpcall", 3'b100, 10'h020, 10'h000, 10'h020, 1, 1'b0);
        step("wrpret",  3'b101, 10'h000, 10'h000, 10'h000, 0, 1'b0);

        step("midcall1", 3'b100, 10'h040, 10'h000, 10'h040, 1, 1'b0);
        step("midcall2", 3'b100, 10'h050, 10'h000, 10'h050, 2, 1'b0);
        rst = 1'b0;
        step("midrst",   3'b101, 10'h000, 10'h000, 10'h000, 0, 1'b0);
        rst = 1'b1;
        step("midret",   3'b101, 10'h000, 10'h000, 10'h000, 0, 1'b1);
        rst = 1'b0;
        step("errrst",   3'b000, 10'h000, 10'h000, 10'h000, 0, 1'b0);
        rst = 1'b1;
`else
        step("load010",  3'b001, 10'h010, 10'h000, 10'h010, 0, 1'b0);
        step("nscall",   3'b100, 10'h100, 10'h000, 10'h010, 0, 1'b0);
        step("nsret",    3'b101, 10'h000, 10'h000, 10'h010, 0, 1'b0);
        step("nscall2",  3'b100, 10'h3AA, 10'h000, 10'h010, 0, 1'b0);
        step("nsinc",    3'b010, 10'h000, 10'h000, 10'h011, 0, 1'b0);
        step("nsret2",   3'b101, 10'h000, 10'h000, 10'h011, 0, 1'b0);
        rst = 1'b0;
        step("nsrst",    3'b010, 10'h000, 10'h000, 10'h000, 0, 1'b0);
        rst = 1'b1;
        step("nsinc2",   3'b010, 10'h000, 10'h000, 10'h001, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
